instr_sequencer: RTL and testbench

Instruction sequencer that buffers operator-entered 16-bit instruction words in a small FIFO and steps each one through the processor state sequence. It drives the `pst` state code and the 4-bit `Opcode` consumed by the control decoder. Its register-field outputs feed the register file and ALU. It qualifies the control decoder's `Reg_Write` into a single-cycle write-back strobe. It runs either single-step (button pulse) or free-run.

---
 rtl/instr_sequencer.sv | 142 ++++++++++++++
 tb/tb_instr_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Instruction sequencer: buffers 16-bit instruction words in a small FIFO and
// steps each one through IDLE -> DECODE -> EXEC -> WB -> DISP.
module instr_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [15:0]             instr_in,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic                    step,
    input  logic                    run,
    input  logic                    Reg_Write,
    output logic [2:0]              pst,
    output logic [3:0]              Opcode,
    output logic [1:0]              rd,
    output logic [1:0]              rs,
    output logic [1:0]              rt,
    output logic [7:0]              imm,
    output logic                    wb_en,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              icount,
    output logic [$clog2(DEPTH):0]  q_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int QW = AW + 1;
    localparam logic [QW-1:0] FULL_LEVEL = QW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        DECODE = 3'b001,
        EXEC   = 3'b010,
        WB     = 3'b011,
        DISP   = 3'b100
    } state_t;

    state_t        state;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [QW-1:0] level;
    logic [15:0]   head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Handshake: a word transfers on any rising edge where instr_valid and
    // instr_ready are both high; a word offered while full is simply dropped.
    // Fullness comes from the registered level, so a same-cycle pop never
    // makes room for a push, and a push into an empty FIFO cannot be popped
    // until the following edge.
    assign full        = (level == FULL_LEVEL);
    assign empty       = (level == '0);
    assign push        = instr_valid & ~full;
    assign pop         = (state == IDLE) & ~empty & (run | step);
    assign head        = mem[rd_ptr];

    assign instr_ready = ~full;
    assign q_level     = level;
    assign pst         = state;
    assign busy        = (state != IDLE);
    assign wb_en       = (state == WB) & Reg_Write;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= instr_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + QW'(1);
                2'b01:   level <= level - QW'(1);
                default: level <= level;
            endcase
        end
    end

    // Field outputs are loaded only on a pop and then held until the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            Opcode <= '0;
            rd     <= '0;
            rs     <= '0;
            rt     <= '0;
            imm    <= '0;
            done   <= 1'b0;
            icount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (pop) begin
                        Opcode <= head[15:12];
                        rd     <= head[11:10];
                        rs     <= head[9:8];
                        rt     <= head[7:6];
                        imm    <= head[7:0];
                        state  <= DECODE;
                    end
                end
                DECODE: begin
                    done  <= 1'b0;
                    state <= EXEC;
                end
                EXEC: begin
                    done  <= 1'b0;
                    state <= WB;
                end
                WB: begin
                    done  <= 1'b1;
                    state <= DISP;
                end
                DISP: begin
                    done   <= 1'b0;
                    icount <= icount + 8'd1;
                    state  <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-cycle state checks, FIFO limits,
// step qualification, async reset abort and icount wrap.
module tb_instr_sequencer;

    logic        clk;
    logic        rst;
    logic [15:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic        step;
    logic        run;
    logic        Reg_Write;
    logic [2:0]  pst;
    logic [3:0]  Opcode;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic [1:0]  rt;
    logic [7:0]  imm;
    logic        wb_en;
    logic        busy;
    logic        done;
    logic [7:0]  icount;
    logic [2:0]  q_level;

    int n_checks = 0;
    int n_fail   = 0;
    int wb_total = 0;
    int wb_base;
    logic [3:0] exp_q[$];

    instr_sequencer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .step(step), .run(run), .Reg_Write(Reg_Write),
        .pst(pst), .Opcode(Opcode), .rd(rd), .rs(rs), .rt(rt), .imm(imm),
        .wb_en(wb_en), .busy(busy), .done(done), .icount(icount), .q_level(q_level)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Control-decoder model: Reg_Write latched at the DECODE edge; NOP(0) and Read(2) do not write.
    always @(posedge clk or negedge rst) begin
        if (!rst) Reg_Write <= 1'b0;
        else if (pst == 3'b001) Reg_Write <= !(Opcode == 4'h0 || Opcode == 4'h2);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: retired opcodes must come out in accepted-push order
    always @(negedge clk) begin
        if (rst && wb_en) wb_total++;
        if (rst && done) begin
            if (exp_q.size() == 0) check("retire_unexpected", 1, 0);
            else check("retire_op", 32'(Opcode), 32'(exp_q.pop_front()));
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        instr_in    = w;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    function automatic logic [2:0] seq_pst(input int i);
        return (i % 5 == 4) ? 3'd0 : 3'(i % 5 + 1);
    endfunction

    logic [2:0] t1_pst  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    logic       t1_wb   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       t1_done [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        rst = 1'b0; instr_in = '0; instr_valid = 1'b0; step = 1'b0; run = 1'b0;
        repeat (2) tick();
        check("rst_pst", pst, 0);
        check("rst_q_level", q_level, 0);
        check("rst_ready", instr_ready, 1);
        check("rst_opcode", Opcode, 0);
        check("rst_icount", icount, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wb_en", wb_en, 0);
        rst = 1'b1;
        tick();

        // single step of ADD 0xA5C0
        push(16'hA5C0); exp_q.push_back(4'hA);
        check("t1_q_level", q_level, 1);
        step = 1'b1; tick(); step = 1'b0;
        check("t1_opcode", Opcode, 4'hA);
        check("t1_rd", rd, 1);
        check("t1_rs", rs, 1);
        check("t1_rt", rt, 3);
        check("t1_imm", imm, 8'hC0);
        check("t1_busy", busy, 1);
        check("t1_q_after_pop", q_level, 0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            check("t1_pst", pst, t1_pst[i]);
            check("t1_wb_en", wb_en, t1_wb[i]);
            check("t1_done", done, t1_done[i]);
        end
        check("t1_icount", icount, 1);
        check("t1_fields_hold", Opcode, 4'hA);

        // NOP and Read in free-run: no write-back
        wb_base = wb_total;
        push(16'h0000); exp_q.push_back(4'h0);
        push(16'h2000); exp_q.push_back(4'h2);
        run = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t2_pst", pst, seq_pst(i));
        end
        run = 1'b0;
        tick();
        check("t2_idle", pst, 0);
        check("t2_no_wb", wb_total - wb_base, 0);
        check("t2_icount", icount, 3);

        // overfill: 5th word dropped, then drain in order
        wb_base = wb_total;
        push(16'h1111); exp_q.push_back(4'h1);
        push(16'h3222); exp_q.push_back(4'h3);
        push(16'h4333); exp_q.push_back(4'h4);
        push(16'h5444); exp_q.push_back(4'h5);
        check("t3_full_level", q_level, 4);
        check("t3_ready_low", instr_ready, 0);
        push(16'h6555);
        check("t3_drop_level", q_level, 4);
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t3_pst", pst, seq_pst(i));
            if (i == 0) check("t3_level_pop", q_level, 3);
        end
        run = 1'b0;
        check("t3_drained", q_level, 0);
        check("t3_ready_high", instr_ready, 1);
        check("t3_wb_count", wb_total - wb_base, 4);
        check("t3_icount", icount, 7);

        // step while busy and step with empty FIFO are ignored
        push(16'h7000); exp_q.push_back(4'h7);
        push(16'h8000); exp_q.push_back(4'h8);
        step = 1'b1; tick();
        check("t4_dispatch", pst, 1);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("t4_busy_pst", pst, seq_pst(i));
        end
        step = 1'b0;
        tick();
        check("t4_back_idle", pst, 0);
        tick();
        check("t4_not_remembered", pst, 0);
        check("t4_level_kept", q_level, 1);
        step = 1'b1; tick(); step = 1'b0;
        check("t4_second", pst, 1);
        repeat (4) tick();
        step = 1'b1; tick(); step = 1'b0;
        check("t4_empty_step", pst, 0);
        check("t4_empty_busy", busy, 0);
        check("t4_icount", icount, 9);

        // simultaneous push and pop at level 2
        push(16'h9000); exp_q.push_back(4'h9);
        push(16'hB000); exp_q.push_back(4'hB);
        instr_in = 16'hC000; instr_valid = 1'b1; run = 1'b1;
        tick();
        instr_valid = 1'b0; exp_q.push_back(4'hC);
        check("t5_push_pop_level", q_level, 2);
        check("t5_dispatch", pst, 1);
        repeat (14) tick();
        run = 1'b0;
        check("t5_drained", q_level, 0);
        check("t5_icount", icount, 12);

        // push into empty FIFO with step high: no fall-through
        instr_in = 16'hD000; instr_valid = 1'b1; step = 1'b1;
        tick();
        instr_valid = 1'b0; step = 1'b0; exp_q.push_back(4'hD);
        check("t5_no_fallthrough", pst, 0);
        check("t5_level_one", q_level, 1);
        step = 1'b1; tick(); step = 1'b0;
        check("t5_next_step", pst, 1);
        repeat (4) tick();
        check("t5_icount2", icount, 13);

        // async reset while in WB
        push(16'hE000); exp_q.push_back(4'hE);
        push(16'hF000);
        step = 1'b1; tick(); step = 1'b0;
        repeat (2) tick();
        check("t6_in_wb", pst, 3);
        check("t6_wb_high", wb_en, 1);
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("t6_rst_pst", pst, 0);
        check("t6_rst_wb_en", wb_en, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_opcode", Opcode, 0);
        check("t6_rst_fields", {rd, rs, rt, imm}, 0);
        check("t6_rst_icount", icount, 0);
        check("t6_rst_level", q_level, 0);
        check("t6_rst_ready", instr_ready, 1);
        tick();
        rst = 1'b1;
        tick();
        push(16'h6A40); exp_q.push_back(4'h6);
        step = 1'b1; tick(); step = 1'b0;
        check("t6_new_opcode", Opcode, 4'h6);
        check("t6_new_rd", rd, 2);
        check("t6_new_rs", rs, 2);
        check("t6_new_rt", rt, 1);
        check("t6_new_imm", imm, 8'h40);
        repeat (4) tick();
        check("t6_icount", icount, 1);

        // 256 free-run instructions wrap icount
        rst = 1'b0; tick(); rst = 1'b1; tick();
        check("t7_start_icount", icount, 0);
        run = 1'b1;
        for (int k = 0; k < 256; k++) begin
            push({4'(k), 12'h000});
            exp_q.push_back(4'(k));
            repeat (4) tick();
        end
        repeat (2) tick();
        run = 1'b0;
        check("t7_wrap_icount", icount, 0);
        check("t7_idle", pst, 0);
        check("t7_scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
